fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 The block SHALL have these ports, one per line, as name  direction  width  meaning:
REQ-002 clk  in  1  clock; all state updates on rising edge.
REQ-003 rst  in  1  reset; asynchronous, active-high.
REQ-004 stall  in  1  decode-stage hold; head instruction is not consumed while 1.
REQ-005 jb  in  1  taken jump/branch redirect from execute.
REQ-006 jb_target  in  16  redirect PC, valid when jb=1.
REQ-007 imem_req  out  1  instruction-memory request.
REQ-008 imem_addr  out  16  request address (fetch PC).
REQ-009 imem_gnt  in  1  request accepted this cycle (req && gnt = handshake).
REQ-010 imem_rvalid  in  1  read data returned, in request order, at least 1 cycle after gnt.
REQ-011 imem_rdata  in  32  returned instruction word.
REQ-012 pc_out  out  16  PC of head instruction; feeds the decode pipeline register.
REQ-013 inst_out  out  32  head instruction, or NOP 0x00000013 when inst_valid=0.
REQ-014 inst_valid  out  1  head entry present.

Function
REQ-015 The block SHALL hold fetch PC register fpc, 2-entry FIFO of {pc,inst}, 2-bit outstanding counter (osd), 2-bit drop counter (drp).
REQ-016 imem_req SHALL be 1 iff jb=0 and (FIFO count + osd) < 2; imem_addr SHALL equal fpc.
REQ-017 On imem_req && imem_gnt, fpc SHALL advance by 4, mod 2^16 (0xFFFC -> 0x0000), and osd SHALL increment.
REQ-018 On imem_rvalid, osd SHALL decrement; combined gnt+rvalid in one cycle leaves osd unchanged.
REQ-019 rvalid with drp>0 SHALL decrement drp and discard data; rvalid with drp=0 and jb=0 SHALL push {pc of that request, imem_rdata}.
REQ-020 Pushed pc SHALL be tracked per request (2-entry in-flight PC queue), not recomputed.
REQ-021 Pop SHALL occur iff inst_valid=1, stall=0, jb=0; simultaneous push and pop SHALL both take effect.
REQ-022 The credit rule SHALL make FIFO overflow impossible; a push when full is an assertion failure.
REQ-023 On jb=1: fpc <= jb_target; FIFO and in-flight PC queue flushed; drp <= osd minus (1 if rvalid this cycle else 0); rvalid data in the jb cycle discarded; jb overrides stall.
REQ-024 Repeated jb while drp>0 SHALL recompute drp per REQ-023 (all pending responses become drops).
REQ-025 Latency: with 1-cycle memory, gnt at cycle t -> rvalid t+1 -> inst_valid at t+2.
REQ-026 Steady state with 1-cycle memory and stall=0 SHALL sustain one instruction per cycle.
REQ-027 inst_out/pc_out SHALL be driven from FIFO head registers/mux only, with no combinational path from imem_rdata.

Reset
REQ-028 While rst=1: fpc=0x0000, FIFO empty, osd=0, drp=0, inst_valid=0, inst_out=0x00000013, pc_out=0x0000, imem_req=0.
REQ-029 Reset mid-transaction SHALL abandon all outstanding requests; memory side is reset by the same rst.
REQ-030 First request after rst deasserts SHALL use address 0x0000 on the first clock edge.

Verification
REQ-031 Reset release, 1-cycle memory, stall=0 -> imem_addr 0x0000,0x0004,0x0008...; inst_valid at cycle 2 with pc_out 0x0000, then one instruction per cycle.
REQ-032 Hold stall=1 for 3 cycles with 2 instructions fetched -> FIFO full, imem_req=0, head pc_out unchanged; release -> PCs continue in order with none lost or duplicated.
REQ-033 jb=1, jb_target=0x0100, two requests outstanding -> next two rvalid discarded, inst_valid=0 until pc_out=0x0100 appears, inst_out=0x00000013 meanwhile.
REQ-034 jb and stall both 1 with FIFO full -> FIFO flushed, fpc=jb_target, imem_req=0 in that cycle.
REQ-035 Start fetch at 0xFFF8 via jb -> addresses 0xFFF8, 0xFFFC, 0x0000.
REQ-036 Random gnt/rvalid delays (0-3 cycles) and random stall/jb -> emitted pc_out sequence matches reference PC model; osd never >2.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch front end: credit-limited requests to instruction memory,
// in-order response tracking, and a 2-entry buffer feeding decode.
module fetch_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        jb,
    input  logic [15:0] jb_target,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [15:0] pc_out,
    output logic [31:0] inst_out,
    output logic        inst_valid
);
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic [15:0] fpc;
    logic [15:0] fifo_pc   [2];
    logic [31:0] fifo_inst [2];
    logic        fifo_rd;
    logic        fifo_wr;
    logic [1:0]  fifo_cnt;
    logic [15:0] ifq_pc    [2];
    logic        ifq_rd;
    logic        ifq_wr;
    logic [1:0]  osd;
    logic [1:0]  drp;

    logic        pop;
    logic        push;
    logic        fetch;
    logic [2:0]  used;

    assign inst_valid = (fifo_cnt != 2'd0);
    assign pc_out     = inst_valid ? fifo_pc[fifo_rd]   : 16'h0000;
    assign inst_out   = inst_valid ? fifo_inst[fifo_rd] : NOP;

    assign pop  = inst_valid && !stall && !jb;
    assign push = imem_rvalid && (drp == 2'd0) && !jb;

    // The head leaving this cycle frees its slot, so a 1-cycle memory streams
    // one instruction per cycle while buffered + outstanding never exceeds two.
    assign used      = {1'b0, fifo_cnt} + {1'b0, osd} - {2'b00, pop};
    assign imem_req  = !rst && !jb && (used < 3'd2);
    assign imem_addr = fpc;
    assign fetch     = imem_req && imem_gnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fpc          <= 16'h0000;
            fifo_rd      <= 1'b0;
            fifo_wr      <= 1'b0;
            fifo_cnt     <= 2'd0;
            ifq_rd       <= 1'b0;
            ifq_wr       <= 1'b0;
            osd          <= 2'd0;
            drp          <= 2'd0;
            fifo_pc[0]   <= 16'h0000;
            fifo_pc[1]   <= 16'h0000;
            fifo_inst[0] <= NOP;
            fifo_inst[1] <= NOP;
            ifq_pc[0]    <= 16'h0000;
            ifq_pc[1]    <= 16'h0000;
        end else begin
            osd <= osd + {1'b0, fetch} - {1'b0, imem_rvalid};
            if (jb) begin
                // Everything still in flight belongs to the wrong path and is dropped on return.
                fpc      <= jb_target;
                fifo_rd  <= 1'b0;
                fifo_wr  <= 1'b0;
                fifo_cnt <= 2'd0;
                ifq_rd   <= 1'b0;
                ifq_wr   <= 1'b0;
                drp      <= osd - {1'b0, imem_rvalid};
            end else begin
                if (fetch) begin
                    fpc            <= fpc + 16'd4;
                    ifq_pc[ifq_wr] <= fpc;
                    ifq_wr         <= ~ifq_wr;
                end
                if (imem_rvalid && (drp != 2'd0)) begin
                    drp <= drp - 2'd1;
                end
                if (push) begin
                    fifo_pc[fifo_wr]   <= ifq_pc[ifq_rd];
                    fifo_inst[fifo_wr] <= imem_rdata;
                    fifo_wr            <= ~fifo_wr;
                    ifq_rd             <= ~ifq_rd;
                end
                if (pop) begin
                    fifo_rd <= ~fifo_rd;
                end
                fifo_cnt <= fifo_cnt + {1'b0, push} - {1'b0, pop};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(push && (fifo_cnt == 2'd2)));
            assert (osd != 2'd3);
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus randomized memory
// timing, stall and redirects compared against a program-order PC model.
module tb_fetch_unit;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        jb;
    logic [15:0] jb_target;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [15:0] pc_out;
    logic [31:0] inst_out;
    logic        inst_valid;

    typedef struct {
        logic [15:0] addr;
        int          due;
    } req_t;

    req_t        mem_q [$];
    int          cyc;
    int          min_dly;
    int          max_dly;
    int          gnt_pct;
    int          checks;
    int          passes;

    logic        obs_req;
    logic [15:0] obs_addr;
    logic        obs_valid;
    logic [15:0] obs_pc;
    logic [31:0] obs_inst;
    logic        obs_hs;

    fetch_unit dut (
        .clk         (clk),
        .rst         (rst),
        .stall       (stall),
        .jb          (jb),
        .jb_target   (jb_target),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .pc_out      (pc_out),
        .inst_out    (inst_out),
        .inst_valid  (inst_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] inst_of(input logic [15:0] a);
        return {~a, a};
    endfunction

    // One cycle: memory responds in order, outputs are sampled, grant decided.
    task automatic apply_stimulus(input logic s, input logic j, input logic [15:0] t);
        req_t r;
        stall     = s;
        jb        = j;
        jb_target = t;
        if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
            r           = mem_q.pop_front();
            imem_rvalid = 1'b1;
            imem_rdata  = inst_of(r.addr);
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = $urandom;
        end
        #1;
        obs_req   = imem_req;
        obs_addr  = imem_addr;
        obs_valid = inst_valid;
        obs_pc    = pc_out;
        obs_inst  = inst_out;
        imem_gnt  = ($urandom_range(99) < gnt_pct);
        obs_hs    = obs_req && imem_gnt;
        if (obs_hs) begin
            mem_q.push_back('{addr: obs_addr, due: cyc + 1 + int'($urandom_range(max_dly, min_dly))});
        end
        @(negedge clk);
        cyc++;
    endtask

    task automatic do_reset();
        rst         = 1'b1;
        stall       = 1'b0;
        jb          = 1'b0;
        jb_target   = 16'h0000;
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        mem_q.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        min_dly = 0; max_dly = 0; gnt_pct = 100;
        do_reset();
        repeat (3) apply_stimulus(1'b0, 1'b0, 16'h0000);
        rst = 1'b1;
        imem_gnt = 1'b0;
        imem_rvalid = 1'b0;
        mem_q.delete();
        #1;
        for (int k = 0; k < 2; k++) begin
            checks++; if (imem_req !== 1'b0) $display("[TB] FAIL rst_req got=%b exp=0", imem_req); else passes++;
            checks++; if (inst_valid !== 1'b0) $display("[TB] FAIL rst_valid got=%b exp=0", inst_valid); else passes++;
            checks++; if (inst_out !== NOP) $display("[TB] FAIL rst_inst got=%h exp=%h", inst_out, NOP); else passes++;
            checks++; if (pc_out !== 16'h0000) $display("[TB] FAIL rst_pc got=%h exp=0000", pc_out); else passes++;
            checks++; if (imem_addr !== 16'h0000) $display("[TB] FAIL rst_addr got=%h exp=0000", imem_addr); else passes++;
            @(negedge clk);
            #1;
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_sequential();
        logic [15:0] exp;
        min_dly = 0; max_dly = 0; gnt_pct = 100;
        do_reset();
        for (int k = 0; k < 10; k++) begin
            apply_stimulus(1'b0, 1'b0, 16'h0000);
            exp = 16'(4 * k);
            checks++; if (obs_req !== 1'b1 || obs_addr !== exp)
                $display("[TB] FAIL seq_addr k=%0d got req=%b addr=%h exp req=1 addr=%h", k, obs_req, obs_addr, exp); else passes++;
            if (k < 2) begin
                checks++; if (obs_valid !== 1'b0 || obs_inst !== NOP)
                    $display("[TB] FAIL seq_empty k=%0d got valid=%b inst=%h exp valid=0 inst=%h", k, obs_valid, obs_inst, NOP); else passes++;
            end else begin
                exp = 16'(4 * (k - 2));
                checks++; if (obs_valid !== 1'b1 || obs_pc !== exp || obs_inst !== inst_of(exp))
                    $display("[TB] FAIL seq_head k=%0d got valid=%b pc=%h inst=%h exp pc=%h", k, obs_valid, obs_pc, obs_inst, exp); else passes++;
            end
        end
    endtask

    task automatic test_stall();
        logic [15:0] exp;
        min_dly = 0; max_dly = 0; gnt_pct = 100;
        do_reset();
        apply_stimulus(1'b0, 1'b0, 16'h0000);
        apply_stimulus(1'b0, 1'b0, 16'h0000);
        for (int k = 0; k < 3; k++) begin
            apply_stimulus(1'b1, 1'b0, 16'h0000);
            checks++; if (obs_req !== 1'b0) $display("[TB] FAIL stall_req k=%0d got=%b exp=0", k, obs_req); else passes++;
            checks++; if (obs_valid !== 1'b1 || obs_pc !== 16'h0000)
                $display("[TB] FAIL stall_head k=%0d got valid=%b pc=%h exp valid=1 pc=0000", k, obs_valid, obs_pc); else passes++;
        end
        exp = 16'h0000;
        for (int k = 0; k < 8; k++) begin
            apply_stimulus(1'b0, 1'b0, 16'h0000);
            checks++; if (obs_valid !== 1'b1 || obs_pc !== exp || obs_inst !== inst_of(exp))
                $display("[TB] FAIL stall_resume k=%0d got valid=%b pc=%h exp pc=%h", k, obs_valid, obs_pc, exp); else passes++;
            exp = exp + 16'd4;
        end
    endtask

    task automatic test_jb_drop();
        logic found;
        min_dly = 2; max_dly = 2; gnt_pct = 100;
        do_reset();
        apply_stimulus(1'b0, 1'b0, 16'h0000);
        apply_stimulus(1'b0, 1'b0, 16'h0000);
        checks++; if (mem_q.size() != 2) $display("[TB] FAIL drop_setup got outstanding=%0d exp=2", mem_q.size()); else passes++;
        apply_stimulus(1'b0, 1'b1, 16'h0100);
        checks++; if (obs_req !== 1'b0) $display("[TB] FAIL drop_jb_req got=%b exp=0", obs_req); else passes++;
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            apply_stimulus(1'b0, 1'b0, 16'h0000);
            if (obs_valid === 1'b1) begin
                found = 1'b1;
                checks++; if (obs_pc !== 16'h0100 || obs_inst !== inst_of(16'h0100))
                    $display("[TB] FAIL drop_first got pc=%h inst=%h exp pc=0100 inst=%h", obs_pc, obs_inst, inst_of(16'h0100)); else passes++;
            end else begin
                checks++; if (obs_inst !== NOP) $display("[TB] FAIL drop_nop k=%0d got=%h exp=%h", k, obs_inst, NOP); else passes++;
            end
        end
        if (!found) begin
            checks++;
            $display("[TB] FAIL drop_timeout got valid=0 exp valid=1 within 20 cycles");
        end
    endtask

    task automatic test_jb_stall_full();
        min_dly = 0; max_dly = 0; gnt_pct = 100;
        do_reset();
        apply_stimulus(1'b0, 1'b0, 16'h0000);
        apply_stimulus(1'b0, 1'b0, 16'h0000);
        apply_stimulus(1'b1, 1'b0, 16'h0000);
        apply_stimulus(1'b1, 1'b0, 16'h0000);
        apply_stimulus(1'b1, 1'b1, 16'h0200);
        checks++; if (obs_req !== 1'b0 || obs_valid !== 1'b1)
            $display("[TB] FAIL jbstall_cycle got req=%b valid=%b exp req=0 valid=1", obs_req, obs_valid); else passes++;
        apply_stimulus(1'b0, 1'b0, 16'h0000);
        checks++; if (obs_valid !== 1'b0 || obs_inst !== NOP)
            $display("[TB] FAIL jbstall_flush got valid=%b inst=%h exp valid=0 inst=%h", obs_valid, obs_inst, NOP); else passes++;
        checks++; if (obs_req !== 1'b1 || obs_addr !== 16'h0200)
            $display("[TB] FAIL jbstall_addr got req=%b addr=%h exp req=1 addr=0200", obs_req, obs_addr); else passes++;
        apply_stimulus(1'b0, 1'b0, 16'h0000);
        apply_stimulus(1'b0, 1'b0, 16'h0000);
        checks++; if (obs_valid !== 1'b1 || obs_pc !== 16'h0200)
            $display("[TB] FAIL jbstall_head got valid=%b pc=%h exp valid=1 pc=0200", obs_valid, obs_pc); else passes++;
    endtask

    task automatic test_wrap();
        logic [15:0] exp_a [3];
        exp_a[0] = 16'hFFF8; exp_a[1] = 16'hFFFC; exp_a[2] = 16'h0000;
        min_dly = 0; max_dly = 0; gnt_pct = 100;
        do_reset();
        apply_stimulus(1'b0, 1'b1, 16'hFFF8);
        for (int k = 0; k < 5; k++) begin
            apply_stimulus(1'b0, 1'b0, 16'h0000);
            if (k < 3) begin
                checks++; if (obs_req !== 1'b1 || obs_addr !== exp_a[k])
                    $display("[TB] FAIL wrap_addr k=%0d got req=%b addr=%h exp addr=%h", k, obs_req, obs_addr, exp_a[k]); else passes++;
            end
            if (k >= 2) begin
                checks++; if (obs_valid !== 1'b1 || obs_pc !== exp_a[k-2])
                    $display("[TB] FAIL wrap_pc k=%0d got valid=%b pc=%h exp pc=%h", k, obs_valid, obs_pc, exp_a[k-2]); else passes++;
            end
        end
    endtask

    // Reference: fetched and consumed PCs each run sequentially from the last redirect.
    task automatic test_random();
        logic [15:0] exp_fetch;
        logic [15:0] exp_pop;
        logic        s;
        logic        j;
        logic [15:0] t;
        int          pops;
        min_dly = 0; max_dly = 3; gnt_pct = 60;
        do_reset();
        exp_fetch = 16'h0000;
        exp_pop   = 16'h0000;
        pops      = 0;
        for (int k = 0; k < 2000; k++) begin
            s = ($urandom_range(99) < 30);
            j = ($urandom_range(99) < 5);
            t = 16'($urandom) & 16'hFFFC;
            apply_stimulus(s, j, t);
            if (obs_hs) begin
                checks++; if (obs_addr !== exp_fetch)
                    $display("[TB] FAIL rnd_addr cyc=%0d got=%h exp=%h", cyc, obs_addr, exp_fetch); else passes++;
                exp_fetch = exp_fetch + 16'd4;
            end
            if (j) begin
                checks++; if (obs_req !== 1'b0) $display("[TB] FAIL rnd_jb_req cyc=%0d got=%b exp=0", cyc, obs_req); else passes++;
            end
            if (obs_valid === 1'b1 && !s && !j) begin
                checks++; if (obs_pc !== exp_pop || obs_inst !== inst_of(exp_pop))
                    $display("[TB] FAIL rnd_pc cyc=%0d got pc=%h inst=%h exp pc=%h inst=%h", cyc, obs_pc, obs_inst, exp_pop, inst_of(exp_pop)); else passes++;
                exp_pop = exp_pop + 16'd4;
                pops++;
            end
            if (obs_valid !== 1'b1) begin
                checks++; if (obs_inst !== NOP) $display("[TB] FAIL rnd_nop cyc=%0d got=%h exp=%h", cyc, obs_inst, NOP); else passes++;
            end
            checks++; if (mem_q.size() > 2) $display("[TB] FAIL rnd_osd cyc=%0d got=%0d exp<=2", cyc, mem_q.size()); else passes++;
            if (j) begin
                exp_fetch = t;
                exp_pop   = t;
            end
        end
        checks++; if (pops < 150) $display("[TB] FAIL rnd_progress got pops=%0d exp>=150", pops); else passes++;
    endtask

    initial begin
        rst         = 1'b1;
        stall       = 1'b0;
        jb          = 1'b0;
        jb_target   = 16'h0000;
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
        cyc         = 0;
        checks      = 0;
        passes      = 0;
        min_dly     = 0;
        max_dly     = 0;
        gnt_pct     = 100;
        test_reset();
        test_sequential();
        test_stall();
        test_jb_drop();
        test_jb_stall_full();
        test_wrap();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
